// File: rtl/mmio_fifo_pkg.sv
// Shared definitions for the MMIO FIFO bank: register offsets within a
// channel's 4-word slot, STATUS bit positions and the status payload struct.
package mmio_fifo_pkg;

    localparam logic [1:0] OFS_DATA   = 2'd0;
    localparam logic [1:0] OFS_STATUS = 2'd2;

    localparam int unsigned ST_EMPTY     = 0;
    localparam int unsigned ST_FULL      = 1;
    localparam int unsigned ST_OVF       = 2;
    localparam int unsigned ST_UNF       = 3;
    localparam int unsigned ST_COUNT_LSB = 8;
    localparam int unsigned ST_DEPTH_LSB = 16;
    localparam int unsigned ST_CHAN_LSB  = 24;

    typedef struct packed {
        logic [7:0] chan;
        logic [7:0] depth;
        logic [7:0] count;
        logic       unf;
        logic       ovf;
        logic       full;
        logic       empty;
    } t_fifo_status;

    // Place status fields at their architectural bit positions; all other bits 0.
    function automatic logic [63:0] status_word(input t_fifo_status s);
        logic [63:0] w;
        w = '0;
        w[ST_EMPTY]              = s.empty;
        w[ST_FULL]               = s.full;
        w[ST_OVF]                = s.ovf;
        w[ST_UNF]                = s.unf;
        w[ST_COUNT_LSB +: 8]     = s.count;
        w[ST_DEPTH_LSB +: 8]     = s.depth;
        w[ST_CHAN_LSB +: 8]      = s.chan;
        return w;
    endfunction

endpackage

// File: rtl/fifo_chan.sv
// One circular FIFO channel with sticky overflow/underflow flags and flush.
// Ports: clk, rst (sync, active-high); push/pop/flush strobes; din in;
// dout = head entry; count, empty, full, ovf (sticky), unf (sticky).
module fifo_chan #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned DEPTH  = 8,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = PTR_W + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic              flush,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic [CNT_W-1:0]  count,
    output logic              empty,
    output logic              full,
    output logic              ovf,
    output logic              unf
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_head;
    logic [PTR_W-1:0]  r_tail;
    logic [CNT_W-1:0]  r_count;
    logic              r_ovf;
    logic              r_unf;

    logic w_empty;
    logic w_full;
    logic w_push_ok;
    logic w_pop_ok;

    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == CNT_W'(DEPTH));
    assign w_pop_ok  = pop && !w_empty;
    // A pop on a full FIFO frees the slot the concurrent push lands in.
    assign w_push_ok = push && (!w_full || pop);

    // Pointers, occupancy and sticky flags; flush returns the channel to idle.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
        end else begin
            if (w_push_ok) r_tail <= r_tail + PTR_W'(1);
            if (w_pop_ok)  r_head <= r_head + PTR_W'(1);
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
            if (push && w_full && !pop) r_ovf <= 1'b1;
            if (pop && w_empty)         r_unf <= 1'b1;
        end
    end

    // Storage is intentionally not reset.
    always_ff @(posedge clk) begin
        if (!rst && !flush && w_push_ok) r_mem[r_tail] <= din;
    end

    assign dout  = r_mem[r_head];
    assign count = r_count;
    assign empty = w_empty;
    assign full  = w_full;
    assign ovf   = r_ovf;
    assign unf   = r_unf;

endmodule

// File: rtl/mmio_fifo_bank.sv
// Bank of NUM_CH FIFOs behind a flat MMIO window of 4 words per channel.
// Ports: clk, rst (sync, active-high); wr_valid/wr_addr/wr_data MMIO write;
// rd_valid/rd_addr/rd_tid MMIO read; rsp_valid/rsp_tid/rsp_data registered
// read response (in-window only); irq_any_err registered OR of sticky flags.
module mmio_fifo_bank
    import mmio_fifo_pkg::*;
#(
    parameter int unsigned NUM_CH    = 4,
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned DATA_W    = 64,
    parameter logic [15:0] BASE_ADDR = 16'h0020
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_valid,
    input  logic [15:0] wr_addr,
    input  logic [63:0] wr_data,
    input  logic        rd_valid,
    input  logic [15:0] rd_addr,
    input  logic [8:0]  rd_tid,
    output logic        rsp_valid,
    output logic [8:0]  rsp_tid,
    output logic [63:0] rsp_data,
    output logic        irq_any_err
);

    localparam int unsigned CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
    localparam logic [16:0] WIN_LO = {1'b0, BASE_ADDR};
    localparam logic [16:0] WIN_HI = WIN_LO + 17'(4 * NUM_CH);

    logic              w_wr_hit;
    logic              w_rd_hit;
    logic [15:0]       w_wr_off;
    logic [15:0]       w_rd_off;
    logic [CH_W-1:0]   w_wr_ch;
    logic [CH_W-1:0]   w_rd_ch;
    logic [1:0]        w_wr_ofs;
    logic [1:0]        w_rd_ofs;

    logic [NUM_CH-1:0] w_push;
    logic [NUM_CH-1:0] w_pop;
    logic [NUM_CH-1:0] w_flush;
    logic [NUM_CH-1:0] w_empty;
    logic [NUM_CH-1:0] w_full;
    logic [NUM_CH-1:0] w_ovf;
    logic [NUM_CH-1:0] w_unf;
    logic [DATA_W-1:0] w_dout  [NUM_CH];
    logic [CNT_W-1:0]  w_count [NUM_CH];

    t_fifo_status      w_status;
    logic [63:0]       w_rd_data;

    logic              r_rsp_valid;
    logic [8:0]        r_rsp_tid;
    logic [63:0]       r_rsp_data;
    logic              r_irq;

    // Window decode; 17-bit compare so a window ending at 16'hFFFF+1 still works.
    assign w_wr_hit = wr_valid && ({1'b0, wr_addr} >= WIN_LO) && ({1'b0, wr_addr} < WIN_HI);
    assign w_rd_hit = rd_valid && ({1'b0, rd_addr} >= WIN_LO) && ({1'b0, rd_addr} < WIN_HI);
    assign w_wr_off = wr_addr - BASE_ADDR;
    assign w_rd_off = rd_addr - BASE_ADDR;
    assign w_wr_ch  = CH_W'(w_wr_off >> 2);
    assign w_rd_ch  = CH_W'(w_rd_off >> 2);
    assign w_wr_ofs = w_wr_off[1:0];
    assign w_rd_ofs = w_rd_off[1:0];

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        assign w_push[c]  = w_wr_hit && (w_wr_ch == CH_W'(c)) && (w_wr_ofs == OFS_DATA);
        assign w_flush[c] = w_wr_hit && (w_wr_ch == CH_W'(c)) && (w_wr_ofs == OFS_STATUS)
                            && wr_data[0];
        assign w_pop[c]   = w_rd_hit && (w_rd_ch == CH_W'(c)) && (w_rd_ofs == OFS_DATA);

        fifo_chan #(
            .DATA_W (DATA_W),
            .DEPTH  (DEPTH)
        ) u_chan (
            .clk   (clk),
            .rst   (rst),
            .push  (w_push[c]),
            .pop   (w_pop[c]),
            .flush (w_flush[c]),
            .din   (wr_data[DATA_W-1:0]),
            .dout  (w_dout[c]),
            .count (w_count[c]),
            .empty (w_empty[c]),
            .full  (w_full[c]),
            .ovf   (w_ovf[c]),
            .unf   (w_unf[c])
        );
    end

    // Read data mux from pre-edge channel state; unused offsets read as zero.
    always_comb begin
        w_status  = '0;
        w_rd_data = '0;
        if (w_rd_ofs == OFS_DATA) begin
            if (!w_empty[w_rd_ch]) w_rd_data = 64'(w_dout[w_rd_ch]);
        end else if (w_rd_ofs == OFS_STATUS) begin
            w_status.empty = w_empty[w_rd_ch];
            w_status.full  = w_full[w_rd_ch];
            w_status.ovf   = w_ovf[w_rd_ch];
            w_status.unf   = w_unf[w_rd_ch];
            w_status.count = 8'(w_count[w_rd_ch]);
            w_status.depth = 8'(DEPTH);
            w_status.chan  = 8'(w_rd_ch);
            w_rd_data      = status_word(w_status);
        end
    end

    // Response register: valid only on the cycle after an in-window read.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rsp_valid <= 1'b0;
            r_rsp_tid   <= '0;
            r_rsp_data  <= '0;
            r_irq       <= 1'b0;
        end else begin
            r_rsp_valid <= w_rd_hit;
            if (w_rd_hit) begin
                r_rsp_tid  <= rd_tid;
                r_rsp_data <= w_rd_data;
            end
            r_irq <= |(w_ovf | w_unf);
        end
    end

    assign rsp_valid   = r_rsp_valid;
    assign rsp_tid     = r_rsp_tid;
    assign rsp_data    = r_rsp_data;
    assign irq_any_err = r_irq;

endmodule

// File: tb/tb_mmio_fifo_bank.sv
// Self-checking bench for mmio_fifo_bank: directed scenarios plus randomized
// traffic, all checked against a queue-based reference model.
module tb_mmio_fifo_bank;

    localparam int unsigned NUM_CH = 4;
    localparam int unsigned DEPTH  = 8;
    localparam int unsigned DATA_W = 64;
    localparam logic [15:0] BASE   = 16'h0020;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_valid = 1'b0;
    logic [15:0] wr_addr = '0;
    logic [63:0] wr_data = '0;
    logic        rd_valid = 1'b0;
    logic [15:0] rd_addr = '0;
    logic [8:0]  rd_tid = '0;
    logic        rsp_valid;
    logic [8:0]  rsp_tid;
    logic [63:0] rsp_data;
    logic        irq_any_err;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [63:0] mq [NUM_CH][$];
    bit          m_ovf [NUM_CH];
    bit          m_unf [NUM_CH];
    logic        exp_valid = 1'b0;
    logic [8:0]  exp_tid = '0;
    logic [63:0] exp_data = '0;
    logic        exp_irq = 1'b0;

    mmio_fifo_bank #(
        .NUM_CH    (NUM_CH),
        .DEPTH     (DEPTH),
        .DATA_W    (DATA_W),
        .BASE_ADDR (BASE)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .wr_valid    (wr_valid),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .rd_valid    (rd_valid),
        .rd_addr     (rd_addr),
        .rd_tid      (rd_tid),
        .rsp_valid   (rsp_valid),
        .rsp_tid     (rsp_tid),
        .rsp_data    (rsp_data),
        .irq_any_err (irq_any_err)
    );

    always #5 clk = ~clk;

    function automatic bit in_win(input logic [15:0] a);
        return (a >= BASE) && (int'(a) < int'(BASE) + 4 * NUM_CH);
    endfunction

    function automatic logic [63:0] mstat(input int c);
        logic [63:0] s;
        int n;
        n = mq[c].size();
        s = '0;
        s[0]     = (n == 0);
        s[1]     = (n == DEPTH);
        s[2]     = m_ovf[c];
        s[3]     = m_unf[c];
        s[15:8]  = 8'(n);
        s[23:16] = 8'(DEPTH);
        s[31:24] = 8'(c);
        return s;
    endfunction

    // One bus cycle: drive at negedge, update model, sample 1 time unit after posedge.
    task automatic step(input logic wv, input logic [15:0] wa, input logic [63:0] wd,
                        input logic rv, input logic [15:0] ra, input logic [8:0] tid);
        int  c;
        int  o;
        logic e;
        @(negedge clk);
        wr_valid = wv; wr_addr = wa; wr_data = wd;
        rd_valid = rv; rd_addr = ra; rd_tid = tid;
        e = 1'b0;
        for (int i = 0; i < NUM_CH; i++) e = e | m_ovf[i] | m_unf[i];
        exp_irq   = e;
        exp_valid = 1'b0;
        if (rv && in_win(ra)) begin
            c = int'(ra - BASE) / 4;
            o = int'(ra - BASE) % 4;
            exp_valid = 1'b1;
            exp_tid   = tid;
            if (o == 0) begin
                if (mq[c].size() == 0) begin
                    exp_data = '0;
                    m_unf[c] = 1'b1;
                end else begin
                    exp_data = mq[c].pop_front();
                end
            end else if (o == 2) begin
                exp_data = mstat(c);
            end else begin
                exp_data = '0;
            end
        end
        if (wv && in_win(wa)) begin
            c = int'(wa - BASE) / 4;
            o = int'(wa - BASE) % 4;
            if (o == 0) begin
                if (mq[c].size() < DEPTH) mq[c].push_back(wd);
                else m_ovf[c] = 1'b1;
            end else if (o == 2 && wd[0]) begin
                mq[c].delete();
                m_ovf[c] = 1'b0;
                m_unf[c] = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        wr_valid = 1'b0;
        rd_valid = 1'b0;
    endtask

    // Reset cycle with a push and an optional read presented, both to be discarded.
    task automatic rst_step(input logic rv, input logic [15:0] ra);
        @(negedge clk);
        rst = 1'b1;
        rd_valid = rv; rd_addr = ra; rd_tid = 9'h1FF;
        wr_valid = 1'b1; wr_addr = BASE; wr_data = 64'h77;
        for (int i = 0; i < NUM_CH; i++) begin
            mq[i].delete();
            m_ovf[i] = 1'b0;
            m_unf[i] = 1'b0;
        end
        exp_valid = 1'b0; exp_tid = '0; exp_data = '0; exp_irq = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0; rd_valid = 1'b0; wr_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst_step(1'b0, 16'h0);
        rst_step(1'b1, 16'h0020);
        checks++;
        if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", rsp_valid); end
        checks++;
        if (rsp_tid !== 9'h0) begin errors++; $display("FAIL reset_tid got %h exp 0", rsp_tid); end
        checks++;
        if (rsp_data !== 64'h0) begin errors++; $display("FAIL reset_data got %h exp 0", rsp_data); end
        checks++;
        if (irq_any_err !== 1'b0) begin errors++; $display("FAIL reset_irq got %b exp 0", irq_any_err); end
        step(1'b0, '0, '0, 1'b1, 16'h0022, 9'h05);
        checks++;
        if (rsp_valid !== 1'b1) begin errors++; $display("FAIL st0_valid got %b exp 1", rsp_valid); end
        checks++;
        if (rsp_tid !== 9'h05) begin errors++; $display("FAIL st0_tid got %h exp 05", rsp_tid); end
        checks++;
        if (rsp_data !== 64'h0000_0000_0008_0001) begin
            errors++; $display("FAIL st0_data got %h exp 0000000000080001", rsp_data);
        end
    endtask

    task automatic test_fill_overflow;
        for (int i = 0; i < 8; i++) step(1'b1, 16'h0020, 64'(8'h11 + i), 1'b0, '0, '0);
        step(1'b1, 16'h0020, 64'h99, 1'b0, '0, '0);
        step(1'b0, '0, '0, 1'b1, 16'h0022, 9'h10);
        checks++;
        if (rsp_data !== 64'h0000_0000_0008_0806) begin
            errors++; $display("FAIL ovf_status got %h exp 0000000000080806", rsp_data);
        end
        for (int i = 0; i < 8; i++) begin
            step(1'b0, '0, '0, 1'b1, 16'h0020, 9'(i));
            checks++;
            if (rsp_valid !== 1'b1 || rsp_data !== 64'(8'h11 + i)) begin
                errors++; $display("FAIL fifo_order[%0d] got %b/%h exp 1/%h", i, rsp_valid, rsp_data, 64'(8'h11 + i));
            end
        end
        step(1'b1, 16'h0022, 64'h1, 1'b0, '0, '0);
        step(1'b0, '0, '0, 1'b0, '0, '0);
        step(1'b0, '0, '0, 1'b0, '0, '0);
    endtask

    task automatic test_underflow_flush;
        step(1'b0, '0, '0, 1'b1, 16'h0028, 9'h20);
        checks++;
        if (rsp_valid !== 1'b1 || rsp_data !== 64'h0) begin
            errors++; $display("FAIL unf_pop got %b/%h exp 1/0", rsp_valid, rsp_data);
        end
        step(1'b0, '0, '0, 1'b1, 16'h002A, 9'h21);
        checks++;
        if (rsp_data !== 64'h0000_0000_0208_0009) begin
            errors++; $display("FAIL unf_status got %h exp 0000000002080009", rsp_data);
        end
        checks++;
        if (irq_any_err !== 1'b1) begin errors++; $display("FAIL irq_set got %b exp 1", irq_any_err); end
        step(1'b1, 16'h002A, 64'h1, 1'b0, '0, '0);
        step(1'b0, '0, '0, 1'b0, '0, '0);
        checks++;
        if (irq_any_err !== 1'b0) begin errors++; $display("FAIL irq_clear got %b exp 0", irq_any_err); end
        step(1'b0, '0, '0, 1'b1, 16'h002A, 9'h22);
        checks++;
        if (rsp_data !== 64'h0000_0000_0208_0001) begin
            errors++; $display("FAIL flush_status got %h exp 0000000002080001", rsp_data);
        end
    endtask

    task automatic test_simul_wrap;
        for (int i = 0; i < 8; i++) step(1'b1, 16'h0024, 64'(8'h31 + i), 1'b0, '0, '0);
        step(1'b1, 16'h0024, 64'hAA, 1'b1, 16'h0024, 9'h31);
        checks++;
        if (rsp_data !== 64'h31) begin errors++; $display("FAIL full_pushpop got %h exp 31", rsp_data); end
        step(1'b0, '0, '0, 1'b1, 16'h0026, 9'h32);
        checks++;
        if (rsp_data !== 64'h0000_0000_0108_0802) begin
            errors++; $display("FAIL full_pushpop_status got %h exp 0000000001080802", rsp_data);
        end
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 16'h0024, 64'(8'hB0 + i), 1'b1, 16'h0024, 9'(i));
            checks++;
            if (rsp_valid !== 1'b1 || rsp_data !== exp_data) begin
                errors++; $display("FAIL wrap[%0d] got %b/%h exp 1/%h", i, rsp_valid, rsp_data, exp_data);
            end
        end
        step(1'b0, '0, '0, 1'b1, 16'h0026, 9'h33);
        checks++;
        if (rsp_data !== 64'h0000_0000_0108_0802) begin
            errors++; $display("FAIL wrap_status got %h exp 0000000001080802", rsp_data);
        end
    endtask

    task automatic test_interleave;
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 16'h0020, 64'(8'hA0 + i), 1'b0, '0, '0);
            step(1'b1, 16'h002C, 64'(8'hD0 + i), 1'b0, '0, '0);
        end
        for (int i = 0; i < 4; i++) begin
            // Pop channel 0 while pushing an extra word to channel 3.
            step(1'b1, 16'h002C, 64'(8'hE0 + i), 1'b1, 16'h0020, 9'h40);
            checks++;
            if (rsp_data !== 64'(8'hA0 + i)) begin
                errors++; $display("FAIL ilv_ch0[%0d] got %h exp %h", i, rsp_data, 64'(8'hA0 + i));
            end
        end
        for (int i = 0; i < 4; i++) begin
            step(1'b0, '0, '0, 1'b1, 16'h002C, 9'h41);
            checks++;
            if (rsp_data !== 64'(8'hD0 + i)) begin
                errors++; $display("FAIL ilv_ch3[%0d] got %h exp %h", i, rsp_data, 64'(8'hD0 + i));
            end
        end
        step(1'b1, 16'h0030, 64'h55, 1'b1, 16'h0010, 9'h42);
        checks++;
        if (rsp_valid !== 1'b0) begin errors++; $display("FAIL oow_0010 got %b exp 0", rsp_valid); end
        step(1'b0, '0, '0, 1'b1, 16'h0030, 9'h43);
        checks++;
        if (rsp_valid !== 1'b0) begin errors++; $display("FAIL oow_0030 got %b exp 0", rsp_valid); end
        step(1'b0, '0, '0, 1'b1, 16'h002F, 9'h44);
        checks++;
        if (rsp_valid !== 1'b1 || rsp_data !== 64'h0) begin
            errors++; $display("FAIL hole_002F got %b/%h exp 1/0", rsp_valid, rsp_data);
        end
        step(1'b0, '0, '0, 1'b1, 16'h002E, 9'h45);
        checks++;
        if (rsp_data !== 64'h0000_0000_0308_0400) begin
            errors++; $display("FAIL ilv_ch3_status got %h exp 0000000003080400", rsp_data);
        end
    endtask

    task automatic test_mid_reset;
        for (int i = 0; i < 5; i++) step(1'b1, 16'h0020, 64'(i), 1'b0, '0, '0);
        rst_step(1'b1, 16'h0020);
        checks++;
        if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_pop_valid got %b exp 0", rsp_valid); end
        step(1'b0, '0, '0, 1'b0, '0, '0);
        checks++;
        if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_pop_late got %b exp 0", rsp_valid); end
        step(1'b0, '0, '0, 1'b1, 16'h0022, 9'h50);
        checks++;
        if (rsp_data !== 64'h0000_0000_0008_0001) begin
            errors++; $display("FAIL rst_status got %h exp 0000000000080001", rsp_data);
        end
    endtask

    task automatic test_random;
        logic [15:0] wa;
        logic [15:0] ra;
        logic [63:0] wd;
        for (int n = 0; n < 600; n++) begin
            wa = 16'(($urandom_range(0, 99) < 65) ? (16'h20 + 4 * $urandom_range(0, 3))
                                                  : $urandom_range(16'h1C, 16'h33));
            ra = 16'(($urandom_range(0, 99) < 60) ? (16'h20 + 4 * $urandom_range(0, 3))
                                                  : $urandom_range(16'h1C, 16'h33));
            wd = {$urandom, $urandom};
            if (wa[1:0] == 2'd2 && $urandom_range(0, 3) != 0) wd[0] = 1'b0;
            step(1'($urandom_range(0, 1)), wa, wd, 1'($urandom_range(0, 1)), ra, 9'($urandom));
            checks++;
            if (rsp_valid !== exp_valid) begin
                errors++; $display("FAIL rand_valid[%0d] got %b exp %b", n, rsp_valid, exp_valid);
            end
            if (exp_valid) begin
                checks++;
                if (rsp_tid !== exp_tid || rsp_data !== exp_data) begin
                    errors++;
                    $display("FAIL rand_rsp[%0d] got %h/%h exp %h/%h", n, rsp_tid, rsp_data, exp_tid, exp_data);
                end
            end
            checks++;
            if (irq_any_err !== exp_irq) begin
                errors++; $display("FAIL rand_irq[%0d] got %b exp %b", n, irq_any_err, exp_irq);
            end
        end
    endtask

    initial begin
        test_reset;
        test_fill_overflow;
        test_underflow_flush;
        test_simul_wrap;
        test_interleave;
        test_mid_reset;
        test_random;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mmio_fifo_bank.md
Name: mmio_fifo_bank

Overview:
- Parametrised bank of NUM_CH independent circular FIFOs, addressed through a flat MMIO register window.
- Generalises the single-register, fixed-depth MMIO FIFO. Adds per-channel status, sticky overflow/underflow flags, flush, configurable width/depth/base address, and pop-on-read.
- Sits inside the AFU between the decoded CCI-P c0 MMIO request fields and the c2 read-response mux.

Parameters:
- NUM_CH, 4: number of FIFO channels (1..16).
- DEPTH, 8: entries per channel. Power of 2, 2..128.
- DATA_W, 64: stored data width (1..64).
- BASE_ADDR, 16'h0020: MMIO word address of channel 0. Must be 4-aligned.

Ports:
- clk  in  1  single clock.
- rst  in  1  synchronous active-high reset.
- wr_valid  in  1  MMIO write strobe (rx.c0.mmioWrValid).
- wr_addr  in  16  MMIO word address of write.
- wr_data  in  64  MMIO write data.
- rd_valid  in  1  MMIO read strobe (rx.c0.mmioRdValid).
- rd_addr  in  16  MMIO word address of read.
- rd_tid  in  9  transaction ID of read.
- rsp_valid  out  1  read response valid; only for addresses inside the window.
- rsp_tid  out  9  echoed TID.
- rsp_data  out  64  read response data.
- irq_any_err  out  1  OR of all sticky overflow/underflow flags.

Behaviour:
- Address map for channel c, A = BASE_ADDR + 4*c:
  - A+0 DATA: write = push, read = pop.
  - A+2 STATUS: read = status word; write with wr_data[0]=1 = flush.
  - A+1 and A+3 are in the window: reads return 0 with rsp_valid=1; writes are ignored.
- Window = [BASE_ADDR, BASE_ADDR+4*NUM_CH). Outside it: no state change, rsp_valid stays 0.
- STATUS word fields:
  - [0] empty
  - [1] full
  - [2] overflow_sticky
  - [3] underflow_sticky
  - [15:8] count
  - [23:16] DEPTH
  - [31:24] channel index
  - all other bits 0.
- Read latency: exactly 1 cycle. rsp_valid, rsp_tid and rsp_data are registered on the clock edge after rd_valid. rsp_valid is 0 on every cycle with no in-window request.
- Push: wr_data[DATA_W-1:0] is written at the tail; the tail pointer and count update on the same edge.
- Pop: rsp_data = head entry zero-extended to 64 bits. The head pointer advances and count decrements on the same edge the response registers.
- Push on full: data dropped, overflow_sticky set, state otherwise unchanged.
- Pop on empty: rsp_data = 0, underflow_sticky set, rsp_valid still 1.
- Simultaneous push and pop, same channel, same cycle:
  - count unchanged.
  - If full: push accepted (the pop frees the slot), no overflow.
  - If empty: pop returns 0 with underflow, push accepted, count becomes 1. No bypass.
- Simultaneous flush and pop, same channel:
  - Response uses the pre-flush state.
  - After the edge: count = 0, pointers = 0, both stickies = 0.
- Flush clears the pointers, count and both sticky flags of that channel only. Stored data is not cleared.
- Pointer wrap: log2(DEPTH)-bit pointers wrap modulo DEPTH. count is log2(DEPTH)+1 bits and saturates logically at DEPTH (full).
- Operations on different channels in the same cycle are fully independent.
- Reset (synchronous, any cycle, including mid-operation):
  - All pointers, counts and sticky flags = 0.
  - rsp_valid = 0, rsp_tid = 0, rsp_data = 0, irq_any_err = 0.
  - Storage is not reset.
  - A request presented in the reset cycle is discarded.
- irq_any_err is registered: it reflects the flag state one cycle after the flag changes.

Decomposition:
- Package mmio_fifo_pkg:
  - Offset constants OFS_DATA=2'd0, OFS_STATUS=2'd2.
  - STATUS bit-position constants.
  - typedef t_fifo_status (packed struct of the status fields).
- Sub-module fifo_chan (DATA_W, DEPTH):
  - Ports: push, pop, flush, din → dout, count, empty, full, ovf, unf.
  - Instantiated NUM_CH times via generate.
  - The top level holds address decode and the response register.

Test Plan:
- Reset, then read STATUS at 16'h0022 with tid 9'h05 → one cycle later rsp_valid=1, rsp_tid=9'h05, rsp_data=64'h0000_0000_0008_0001 (DEPTH=8, empty).
- Push 0x11..0x18 to 16'h0020, then a 9th push 0x99 → STATUS = 64'h0000_0000_0008_0806 (full, ovf). Eight pops then return 0x11..0x18 in order.
- Pop empty channel 2 at 16'h0028 → rsp_data=0, rsp_valid=1. STATUS at 16'h002A = 0x0208_0009. irq_any_err=1 one cycle later. Write 1 to 16'h002A → flag cleared, irq_any_err=0.
- Fill channel 1 (16'h0024) to 8 entries, then pop and push 0xAA in the same cycle → pop returns first entry, count stays 8, no ovf. Continue 20 push/pop pairs to exercise wrap; data order is preserved.
- Interleave channels 0 and 3 (0xA0.., 0xD0..) → no cross-talk. Reads at 16'h0010 and 16'h0030 → rsp_valid stays 0.
- Assert rst mid-stream with channel 0 at count 5 → next STATUS read shows count 0, empty=1. A pop in the reset cycle produces no response.
